// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a byte-addressed data memory.
// Checks alignment and range, drives the memory port for WAIT_CYCLES+1 cycles,
// and returns the load data and error code under a valid/ready handshake.
package lsu_mem_ctrl_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_size_t;
endpackage

module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  mem_size_t   req_size,
  input  logic        req_zero_extend,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        dmem_reg,
  output logic        dmem_wr_en,
  output mem_size_t   dmem_data_size,
  output logic        dmem_zero_extend,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wr_data,
  input  logic [31:0] dmem_rd_data
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, zext_q;
  mem_size_t   size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  cnt_q;
  logic [1:0]  err_q;

  logic        misaligned, out_of_range, last_cycle;
  logic [32:0] last_byte;
  logic [1:0]  req_err;

  assign last_cycle = (cnt_q == 4'd0);

  // Classify the incoming request; the last byte is computed at 33 bits so a
  // word near 2**32 cannot wrap back into range. Misalignment wins over range.
  always_comb begin
    misaligned = 1'b0;
    last_byte  = {1'b0, req_addr};
    case (req_size)
      HALF_WORD: begin
        misaligned = req_addr[0];
        last_byte  = {1'b0, req_addr} + 33'd1;
      end
      WORD: begin
        misaligned = |req_addr[1:0];
        last_byte  = {1'b0, req_addr} + 33'd3;
      end
      default: ;
    endcase
    out_of_range = (last_byte >> ADDR_WIDTH) != 33'd0;
    req_err      = misaligned ? 2'd1 : (out_of_range ? 2'd2 : 2'd0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and outputs; dmem_* are decoded from state so reset drops them at once
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    busy             = (state_q != IDLE);
    dmem_reg         = 1'b0;
    dmem_wr_en       = 1'b0;
    dmem_data_size   = BYTE;
    dmem_zero_extend = 1'b0;
    dmem_addr        = '0;
    dmem_wr_data     = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_err != 2'd0) ? RESP : ACCESS;
      end
      ACCESS: begin
        dmem_reg         = 1'b1;
        dmem_wr_en       = we_q && last_cycle;
        dmem_data_size   = size_q;
        dmem_zero_extend = zext_q;
        dmem_addr        = addr_q;
        dmem_wr_data     = wdata_q;
        if (last_cycle) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      size_q  <= BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            zext_q  <= req_zero_extend;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WAIT_INIT;
            rdata_q <= '0;
            err_q   <= req_err;
          end
        end
        ACCESS: begin
          if (!last_cycle)  cnt_q   <= cnt_q - 4'd1;
          else if (!we_q)   rdata_q <= dmem_rd_data;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: one instance with WAIT_CYCLES=0 and one with 3, each
// attached to its own little-endian byte memory model.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic        req_valid0 = 1'b0, req_valid3 = 1'b0;
  logic        req_we = 1'b0, req_zext = 1'b0, rsp_ready = 1'b1;
  mem_size_t   req_size = BYTE;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        req_ready0, rsp_valid0, busy0, dmem_reg0, dmem_wr_en0, dmem_zext0;
  logic [31:0] rsp_rdata0, dmem_addr0, dmem_wr_data0, dmem_rd_data0;
  logic [1:0]  rsp_err0;
  mem_size_t   dmem_size0;
  logic        req_ready3, rsp_valid3, busy3, dmem_reg3, dmem_wr_en3, dmem_zext3;
  logic [31:0] rsp_rdata3, dmem_addr3, dmem_wr_data3, dmem_rd_data3;
  logic [1:0]  rsp_err3;
  mem_size_t   dmem_size3;

  lsu_mem_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_zero_extend(req_zext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .busy(busy0), .dmem_reg(dmem_reg0), .dmem_wr_en(dmem_wr_en0),
    .dmem_data_size(dmem_size0), .dmem_zero_extend(dmem_zext0),
    .dmem_addr(dmem_addr0), .dmem_wr_data(dmem_wr_data0), .dmem_rd_data(dmem_rd_data0)
  );

  lsu_mem_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_size(req_size), .req_zero_extend(req_zext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .busy(busy3), .dmem_reg(dmem_reg3), .dmem_wr_en(dmem_wr_en3),
    .dmem_data_size(dmem_size3), .dmem_zero_extend(dmem_zext3),
    .dmem_addr(dmem_addr3), .dmem_wr_data(dmem_wr_data3), .dmem_rd_data(dmem_rd_data3)
  );

  // Memory models
  logic [7:0]  mem0 [0:65535] = '{default: 8'h00};
  logic [7:0]  mem3 [0:65535] = '{default: 8'h00};
  int          wr_cnt0 = 0, wr_cnt3 = 0;
  logic [31:0] last_wa0 = '0, last_wa3 = '0;

  function automatic logic [31:0] ext_rd(input logic [31:0] w, input mem_size_t s, input logic z);
    case (s)
      BYTE:      return z ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      HALF_WORD: return z ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default:   return w;
    endcase
  endfunction

  assign dmem_rd_data0 = dmem_reg0 ? ext_rd({mem0[dmem_addr0[15:0] + 16'd3], mem0[dmem_addr0[15:0] + 16'd2],
                                             mem0[dmem_addr0[15:0] + 16'd1], mem0[dmem_addr0[15:0]]},
                                            dmem_size0, dmem_zext0) : '0;
  assign dmem_rd_data3 = dmem_reg3 ? ext_rd({mem3[dmem_addr3[15:0] + 16'd3], mem3[dmem_addr3[15:0] + 16'd2],
                                             mem3[dmem_addr3[15:0] + 16'd1], mem3[dmem_addr3[15:0]]},
                                            dmem_size3, dmem_zext3) : '0;

  always @(posedge clk) begin
    if (dmem_reg0 && dmem_wr_en0) begin
      wr_cnt0  <= wr_cnt0 + 1;
      last_wa0 <= dmem_addr0;
      mem0[dmem_addr0[15:0]] <= dmem_wr_data0[7:0];
      if (dmem_size0 != BYTE) mem0[dmem_addr0[15:0] + 16'd1] <= dmem_wr_data0[15:8];
      if (dmem_size0 == WORD) begin
        mem0[dmem_addr0[15:0] + 16'd2] <= dmem_wr_data0[23:16];
        mem0[dmem_addr0[15:0] + 16'd3] <= dmem_wr_data0[31:24];
      end
    end
    if (dmem_reg3 && dmem_wr_en3) begin
      wr_cnt3  <= wr_cnt3 + 1;
      last_wa3 <= dmem_addr3;
      mem3[dmem_addr3[15:0]] <= dmem_wr_data3[7:0];
      if (dmem_size3 != BYTE) mem3[dmem_addr3[15:0] + 16'd1] <= dmem_wr_data3[15:8];
      if (dmem_size3 == WORD) begin
        mem3[dmem_addr3[15:0] + 16'd2] <= dmem_wr_data3[23:16];
        mem3[dmem_addr3[15:0] + 16'd3] <= dmem_wr_data3[31:24];
      end
    end
  end

  // Observation mux selecting which instance a transaction targets
  logic        sel = 1'b0;
  logic        o_req_ready, o_rsp_valid, o_dmem_reg, o_dmem_zext;
  logic [31:0] o_rsp_rdata, o_last_wa;
  logic [1:0]  o_rsp_err;
  int          o_wr_cnt;
  assign o_req_ready = sel ? req_ready3 : req_ready0;
  assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid0;
  assign o_dmem_reg  = sel ? dmem_reg3  : dmem_reg0;
  assign o_dmem_zext = sel ? dmem_zext3 : dmem_zext0;
  assign o_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata0;
  assign o_rsp_err   = sel ? rsp_err3   : rsp_err0;
  assign o_last_wa   = sel ? last_wa3   : last_wa0;
  assign o_wr_cnt    = sel ? wr_cnt3    : wr_cnt0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    mem_size_t   size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
  } vec_t;

  // One full transaction on the selected instance with rsp_ready held high
  task automatic do_txn(input logic d, input vec_t v);
    int k, dreg, wc, w, exp_lat;
    logic zx_ok;
    sel = d;
    w   = d ? 3 : 0;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_zext = v.zext;
    req_addr = v.addr; req_wdata = v.wdata;
    if (d) req_valid3 = 1'b1; else req_valid0 = 1'b1;
    k = 0;
    while (!o_req_ready && k < 20) begin @(negedge clk); k++; end
    chk({v.name, "_req_ready"}, 32'(o_req_ready), 32'd1);
    wc = o_wr_cnt;
    @(posedge clk);
    #1 req_valid0 = 1'b0; req_valid3 = 1'b0;
    dreg = 0; k = 0; zx_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (o_dmem_reg) begin
        dreg++;
        if (o_dmem_zext !== v.zext) zx_ok = 1'b0;
      end
    end while (!o_rsp_valid && k < 30);
    exp_lat = (v.err != 2'd0) ? 1 : w + 2;
    chk({v.name, "_latency"}, 32'(k), 32'(exp_lat));
    chk({v.name, "_rdata"}, o_rsp_rdata, v.rdata);
    chk({v.name, "_err"}, 32'(o_rsp_err), 32'(v.err));
    chk({v.name, "_dmem_reg_cycles"}, 32'(dreg), (v.err != 2'd0) ? 32'd0 : 32'(w + 1));
    chk({v.name, "_writes"}, 32'(o_wr_cnt - wc), (v.we && v.err == 2'd0) ? 32'd1 : 32'd0);
    if (v.we && v.err == 2'd0) chk({v.name, "_write_addr"}, o_last_wa, v.addr);
    if (!v.we && v.err == 2'd0) chk({v.name, "_zext_follow"}, 32'(zx_ok), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"sw_0010",   1'b1, WORD,      1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0});
    vecs.push_back('{"lw_0010",   1'b0, WORD,      1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2'd0});
    vecs.push_back('{"sb_0003",   1'b1, BYTE,      1'b0, 32'h0000_0003, 32'h0000_0080, 32'h0000_0000, 2'd0});
    vecs.push_back('{"lb_0003",   1'b0, BYTE,      1'b0, 32'h0000_0003, 32'h0,         32'hFFFF_FF80, 2'd0});
    vecs.push_back('{"lbu_0003",  1'b0, BYTE,      1'b1, 32'h0000_0003, 32'h0,         32'h0000_0080, 2'd0});
    vecs.push_back('{"lw_0002",   1'b0, WORD,      1'b0, 32'h0000_0002, 32'h0,         32'h0000_0000, 2'd1});
    vecs.push_back('{"sh_0001",   1'b1, HALF_WORD, 1'b0, 32'h0000_0001, 32'h0000_1234, 32'h0000_0000, 2'd1});
    vecs.push_back('{"sw_fffc",   1'b1, WORD,      1'b0, 32'h0000_FFFC, 32'h1122_3344, 32'h0000_0000, 2'd0});
    vecs.push_back('{"lw_fffc",   1'b0, WORD,      1'b0, 32'h0000_FFFC, 32'h0,         32'h1122_3344, 2'd0});
    vecs.push_back('{"lh_fffe",   1'b0, HALF_WORD, 1'b0, 32'h0000_FFFE, 32'h0,         32'h0000_1122, 2'd0});
    vecs.push_back('{"lb_ffff",   1'b0, BYTE,      1'b0, 32'h0000_FFFF, 32'h0,         32'h0000_0011, 2'd0});
    vecs.push_back('{"lw_10000",  1'b0, WORD,      1'b0, 32'h0001_0000, 32'h0,         32'h0000_0000, 2'd2});
    vecs.push_back('{"sb_10000",  1'b1, BYTE,      1'b0, 32'h0001_0000, 32'h0000_00FF, 32'h0000_0000, 2'd2});
    vecs.push_back('{"lh_ffff",   1'b0, HALF_WORD, 1'b0, 32'h0000_FFFF, 32'h0,         32'h0000_0000, 2'd1});
    vecs.push_back('{"lw_fffffffc", 1'b0, WORD,    1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 2'd2});
    vecs.push_back('{"sh_0020",   1'b1, HALF_WORD, 1'b0, 32'h0000_0020, 32'h5555_BEEF, 32'h0000_0000, 2'd0});
    vecs.push_back('{"lh_0020",   1'b0, HALF_WORD, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_BEEF, 2'd0});
    vecs.push_back('{"lhu_0020",  1'b0, HALF_WORD, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_BEEF, 2'd0});
    vecs.push_back('{"lw_0020",   1'b0, WORD,      1'b0, 32'h0000_0020, 32'h0,         32'h0000_BEEF, 2'd0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("in_reset_dmem", {28'd0, dmem_reg0, dmem_wr_en0, dmem_reg3, dmem_wr_en3}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_ctrl0", {26'd0, req_ready0, rsp_valid0, busy0, dmem_reg0, dmem_wr_en0, dmem_zext0}, 32'h20);
    chk("rst_ctrl3", {26'd0, req_ready3, rsp_valid3, busy3, dmem_reg3, dmem_wr_en3, dmem_zext3}, 32'h20);
    chk("rst_rdata0", rsp_rdata0, 32'd0);
    chk("rst_err0", 32'(rsp_err0), 32'd0);
    chk("rst_dmem_addr0", dmem_addr0, 32'd0);
    chk("rst_dmem_wdata0", dmem_wr_data0, 32'd0);
    chk("rst_dmem_size0", 32'(dmem_size0), 32'd0);

    // Directed vector table on the zero-wait instance
    foreach (vecs[i]) do_txn(1'b0, vecs[i]);

    // Wait cycles and response backpressure on the three-wait instance
    begin
      int wc;
      sel = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_we = 1'b1; req_size = WORD; req_zext = 1'b0;
      req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
      req_valid3 = 1'b1;
      chk("bp_req_ready", 32'(req_ready3), 32'd1);
      wc = wr_cnt3;
      @(posedge clk);
      #1;
      // A competing request held during the transaction must be ignored
      req_we = 1'b0; req_addr = 32'h0000_0080; req_wdata = 32'h0;
      for (int k = 1; k <= 9; k++) begin
        logic acc, rsp;
        @(negedge clk);
        acc = (k <= 4);
        rsp = (k >= 5);
        chk($sformatf("bp_ctrl_c%0d", k),
            {27'd0, dmem_reg3, dmem_wr_en3, busy3, req_ready3, rsp_valid3},
            {27'd0, acc, acc && (k == 4), 1'b1, 1'b0, rsp});
        if (acc) chk($sformatf("bp_addr_c%0d", k), dmem_addr3, 32'h0000_0040);
        if (rsp) chk($sformatf("bp_rsp_c%0d", k), {rsp_rdata3[29:0], rsp_err3}, 32'd0);
      end
      req_valid3 = 1'b0;
      rsp_ready  = 1'b1;
      @(negedge clk);
      chk("bp_released", {30'd0, rsp_valid3, req_ready3}, 32'd1);
      chk("bp_writes", 32'(wr_cnt3 - wc), 32'd1);
      do_txn(1'b1, '{"w3_lw_0040", 1'b0, WORD, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2'd0});
    end

    // Reset during the commit cycle of a store must suppress the write
    begin
      int wc;
      do_txn(1'b1, '{"w3_sw_0050", 1'b1, WORD, 1'b0, 32'h0000_0050, 32'h1111_1111, 32'h0, 2'd0});
      sel = 1'b1;
      wc = wr_cnt3;
      @(negedge clk);
      req_we = 1'b1; req_size = WORD; req_zext = 1'b0;
      req_addr = 32'h0000_0050; req_wdata = 32'h2222_2222;
      req_valid3 = 1'b1;
      @(posedge clk);
      #1 req_valid3 = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_wren_before", 32'(dmem_wr_en3), 32'd1);
      rst3 = 1'b1;
      #1;
      chk("rst_mid_ctrl", {28'd0, dmem_reg3, dmem_wr_en3, busy3, rsp_valid3}, 32'd0);
      chk("rst_mid_dmem", dmem_addr3 | dmem_wr_data3, 32'd0);
      chk("rst_mid_rsp", {rsp_rdata3[29:0], rsp_err3}, 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      chk("rst_mid_after", {30'd0, req_ready3, busy3}, 32'd2);
      chk("rst_mid_writes", 32'(wr_cnt3 - wc), 32'd0);
      do_txn(1'b1, '{"w3_lw_0050", 1'b0, WORD, 1'b0, 32'h0000_0050, 32'h0, 32'h1111_1111, 2'd0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
